// File: rtl/reshuffle_stream_unit.sv
// Registered NxN patch permutation stage with valid/ready handshake.
// The rotation step is tracked internally: it advances on every accepted
// patch and reloads from cfg_step_init at each tile-row boundary.
module reshuffle_stream_unit #(
    parameter int N             = 4,
    parameter int WIDTH         = 32,
    parameter int TILES_PER_ROW = 8
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [1:0]                                cfg_mode,
    input  logic [$clog2(N)-1:0]                      cfg_step_init,
    input  logic [$clog2(N)-1:0]                      cfg_step_inc,
    input  logic                                      clear,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic signed [0:N-1][0:N-1][WIDTH-1:0]     in_patch,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic signed [0:N-1][0:N-1][WIDTH-1:0]     out_patch,
    output logic [$clog2(N)-1:0]                      out_step,
    output logic                                      out_row_last
);

    localparam int SW = $clog2(N);
    localparam int CW = (TILES_PER_ROW > 1) ? $clog2(TILES_PER_ROW) : 1;

    // One extra bit so index sums never wrap before the modulo is taken.
    typedef logic [SW:0] ext_t;
    typedef logic signed [0:N-1][0:N-1][WIDTH-1:0] patch_t;

    // Reduce a value below 3N into [0, N). Every caller guarantees the
    // bound: index sums are below 2N, step + inc is below 3N since the
    // stored step is always already reduced.
    function automatic logic [SW-1:0] mod_n(input ext_t x);
        ext_t y;
        y = x;
        if (y >= ext_t'(N)) begin
            y = y - ext_t'(N);
        end else begin
            y = y;
        end
        if (y >= ext_t'(N)) begin
            y = y - ext_t'(N);
        end else begin
            y = y;
        end
        return SW'(y);
    endfunction

    logic              out_valid_q;
    patch_t            out_patch_q;
    logic [SW-1:0]     out_step_q;
    logic              out_row_last_q;
    logic [SW-1:0]     step_q;
    logic [CW-1:0]     cnt_q;

    patch_t            perm_d;
    logic [SW-1:0]     step_d;
    logic [CW-1:0]     cnt_d;
    logic              row_end_s;
    logic              in_ready_s;
    logic              accept_s;

    assign in_ready_s = !out_valid_q || out_ready;
    assign accept_s   = in_valid && in_ready_s;

    // Build the permuted patch from the current step and mode.
    always_comb begin
        perm_d = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                case (cfg_mode)
                    2'd0:    perm_d[r][c] = in_patch[r][c];
                    2'd1:    perm_d[r][c] = in_patch[mod_n(ext_t'(r) + {1'b0, step_q})][c];
                    2'd2:    perm_d[r][c] = in_patch[r][mod_n(ext_t'(c) + {1'b0, step_q})];
                    2'd3:    perm_d[r][c] = in_patch[c][mod_n(ext_t'(r) + {1'b0, step_q})];
                    default: perm_d[r][c] = in_patch[r][c];
                endcase
            end
        end
    end

    // Next step and patch count for an accepted patch; reload at row end.
    always_comb begin
        row_end_s = (cnt_q == CW'(TILES_PER_ROW - 1));
        cnt_d     = cnt_q;
        step_d    = step_q;
        if (row_end_s) begin
            cnt_d  = '0;
            step_d = mod_n({1'b0, cfg_step_init});
        end else begin
            cnt_d  = cnt_q + CW'(1);
            step_d = mod_n({1'b0, step_q} + {1'b0, cfg_step_inc});
        end
    end

    // Output register, step and count state; reset and clear discard all.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            out_valid_q    <= 1'b0;
            out_patch_q    <= '0;
            out_step_q     <= '0;
            out_row_last_q <= 1'b0;
            step_q         <= mod_n({1'b0, cfg_step_init});
            cnt_q          <= '0;
        end else if (accept_s) begin
            out_valid_q    <= 1'b1;
            out_patch_q    <= perm_d;
            out_step_q     <= step_q;
            out_row_last_q <= row_end_s;
            step_q         <= step_d;
            cnt_q          <= cnt_d;
        end else if (out_ready) begin
            out_valid_q    <= 1'b0;
        end else begin
            out_valid_q    <= out_valid_q;
        end
    end

    assign in_ready     = in_ready_s;
    assign out_valid    = out_valid_q;
    assign out_patch    = out_patch_q;
    assign out_step     = out_step_q;
    assign out_row_last = out_row_last_q;

endmodule

// File: doc/reshuffle_stream_unit.md
Name: reshuffle_stream_unit

Overview:
- Registered, handshaked successor to the combinational patch-permutation stage between the PosT array and the output buffer.
- Accepts one NxN patch per transfer and applies a runtime-selected permutation: bypass, row rotation, column rotation, or transpose followed by row rotation.
- Tracks the rotation step internally: it advances per accepted patch and reloads at tile-row boundaries, so upstream no longer drives the step.
- Provides one-deep output registration with full-throughput valid/ready backpressure.

Parameters:
- N, 4, patch dimension (N >= 2; need not be a power of two).
- WIDTH, 32, signed element width.
- TILES_PER_ROW, 8, accepted patches per tile row before the step reloads (>= 1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cfg_mode  in  2  permutation: 0 bypass, 1 row-rot, 2 col-rot, 3 transpose+row-rot.
- cfg_step_init  in  $clog2(N)  step value loaded at reset, clear, and row boundary.
- cfg_step_inc  in  $clog2(N)  step increment per accepted patch.
- clear  in  1  synchronous soft clear of step, patch count and pipeline.
- in_valid  in  1  input patch valid.
- in_ready  out  1  unit can accept a patch.
- in_patch  in  signed WIDTH [0:N-1][0:N-1]  input patch.
- out_valid  out  1  output patch valid.
- out_ready  in  1  downstream accepts the output patch.
- out_patch  out  signed WIDTH [0:N-1][0:N-1]  permuted patch.
- out_step  out  $clog2(N)  step used for this output patch.
- out_row_last  out  1  output patch is the last of its tile row.

Behaviour:
- Accept condition: in_valid && in_ready. Output transfer condition: out_valid && out_ready.
- in_ready = !out_valid || out_ready (combinational). A new patch may be accepted in the same cycle the held one drains, giving 1 patch/cycle sustained.
- Latency: exactly 1 cycle from accept to out_valid.
- Output hold: while out_valid && !out_ready, out_patch, out_step and out_row_last hold stable.
- Permutation is applied at accept, using the current step s and cfg_mode sampled that cycle:
  - mode 0: out[r][c] = in[r][c].
  - mode 1: out[r][c] = in[(r+s) mod N][c].
  - mode 2: out[r][c] = in[r][(c+s) mod N].
  - mode 3: out[r][c] = in[c][(r+s) mod N], i.e. transpose then row-rotate.
- Modulo arithmetic: computed in a width of $clog2(N)+1 bits, with no truncation error for non-power-of-two N.
- Step and patch count update on each accept:
  - if cnt == TILES_PER_ROW-1: cnt <= 0, step <= cfg_step_init, and the output is tagged row_last = 1.
  - otherwise: cnt <= cnt+1, step <= (step + cfg_step_inc) mod N.
- out_step reports the pre-update step, i.e. the step used for that patch.
- Config changes take effect on the next accept. The held output is never re-permuted.
- Reset (rst=1):
  - out_valid=0; out_patch, out_step and out_row_last all 0.
  - step <= cfg_step_init, cnt <= 0.
  - in_ready = 1 in the first cycle after reset.
- Reset mid-transfer: a held output is discarded and no partial state survives.
- clear: identical effect to rst, but only while rst=0. An accept coincident with clear is dropped, because clear has priority.
- Patch elements pass through bit-exact; no arithmetic is applied to data.

Test Plan:
- Reset/idle: assert rst 2 cycles with cfg_step_init=1 -> out_valid=0, out_patch all 0, in_ready=1; first accepted patch reports out_step=1.
- Row rotation streaming: N=4, mode 1, init 0, inc 1, in[r][c]=10r+c, 4 back-to-back patches with out_ready=1:
  - out_step = 0,1,2,3.
  - patch 2 out[0][*] = 20,21,22,23.
  - one output per cycle, latency 1.
- Column and transpose: mode 2, s=3 -> out[1][0] = in[1][3] = 13. Mode 3, s=1 -> out[0][2] = in[2][1] = 21.
- Backpressure: out_ready low 3 cycles with in_valid held high -> in_ready=0, out_patch stable, no step advance; on release the next patch follows with no loss or duplication.
- Row boundary: TILES_PER_ROW=8, init 2, inc 1, N=4:
  - out_step sequence 2,3,0,1,2,3,0,1 | 2.
  - out_row_last=1 only on the 8th patch.
- Clear and non-pow2: N=3, inc 2 -> steps 0,2,1,0. Assert clear with out_valid=1 and in_valid=1 -> next cycle out_valid=0, the coincident input is dropped, step=init.
